mapper_rom_fetch: RTL and testbench
===================================

Name: mapper_rom_fetch

Overview:
- Downstream stage of the cartridge mapper blocks.
- Consumes the mapper output (ram_cs plus 27-bit physical ROM address) and turns it into a level-handshake read on the SDRAM port.
- Holds the CPU with a wait signal until the SDRAM returns data, then presents the byte for one cycle.
- Reads of unmapped space return 8'hFF without touching SDRAM. A hung SDRAM access is bounded by a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the access is aborted. Must be ≥ 1.
- UNMAPPED_DATA, 8'hFF: byte returned for unmapped reads and timed-out reads.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  single-cycle access strobe from the CPU bus
- cpu_rd  in  1  access is a read (qualifies cpu_req)
- map_ram_cs  in  1  mapper says this access hits ROM
- map_addr  in  27  mapper physical address (valid when map_ram_cs)
- cpu_wait  out  1  CPU wait request
- cpu_data  out  8  read data
- cpu_data_valid  out  1  one-cycle pulse; cpu_data is valid in that cycle
- sdram_req  out  1  read request level, held until ack
- sdram_addr  out  27  read address, stable while sdram_req
- sdram_ack  in  1  request accepted and data returned this cycle
- sdram_rdata  in  8  read data, sampled when sdram_ack
- timeout_err  out  1  sticky flag, set on any timeout

Behaviour:
- All state changes occur on posedge clk. Reset is synchronous and active-high; it overrides every other input in that cycle.
- Reset values:
  - FSM = IDLE.
  - sdram_req = 0, sdram_addr = 0.
  - cpu_data = 8'hFF, cpu_data_valid = 0, timeout_err = 0.
  - Timeout counter = 0.
- start = cpu_req & cpu_rd & map_ram_cs & (state == IDLE).
- cpu_wait is combinational: cpu_wait = start | (state == ISSUE) | (state == WAIT). This stalls the CPU in the same cycle as its strobe.
- State IDLE:
  - On start: latch map_addr into sdram_addr, clear the counter, go to ISSUE.
  - On cpu_req & cpu_rd & ~map_ram_cs: cpu_data <= UNMAPPED_DATA, pulse cpu_data_valid the next cycle, stay in IDLE, no SDRAM activity, no wait.
  - Writes (cpu_req & ~cpu_rd) are ignored entirely.
- State ISSUE: sdram_req <= 1 (registered, so it rises one cycle after start). Go to WAIT.
- State WAIT:
  - sdram_req stays 1 and sdram_addr is held. The counter increments each cycle.
  - On sdram_ack: cpu_data <= sdram_rdata, sdram_req <= 0, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: cpu_data <= UNMAPPED_DATA, sdram_req <= 0, timeout_err <= 1, go to DONE.
  - If ack and timeout coincide, ack wins: real data is returned and timeout_err is not set.
- State DONE: cpu_data_valid = 1 for exactly this cycle, cpu_wait = 0. Go to IDLE.
- Back-to-back reads: the earliest next start is the cycle after DONE.
- Minimum mapped-read latency: start at cycle N, sdram_req high at N+1, ack at N+1, data valid at N+2. Wait is high for cycles N and N+1.
- cpu_req while busy (ISSUE/WAIT/DONE) is ignored. It is not queued.
- sdram_ack while not in WAIT is ignored.
- Reset mid-access:
  - sdram_req drops in the cycle after reset is sampled.
  - A late ack after reset is ignored.
  - No cpu_data_valid is produced for the aborted access.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it does not wrap during a single access.

Optional Feature:
- Macro: MAPPER_ROM_FETCH_CACHE_EN.
- Enabled: a single-entry read cache holds tag[26:0], data[7:0] and a valid bit.
  - Filled on every sdram_ack.
  - Invalidated by reset and by a timeout.
  - In IDLE, a mapped read whose map_addr equals the valid tag is a hit: no start, cpu_wait = 0, no sdram_req, cpu_data <= cached byte, cpu_data_valid pulses the next cycle.
  - Misses behave exactly as without the cache.
- Disabled: no cache storage. Every mapped read goes to SDRAM. Behaviour is exactly as in the Behaviour section.

Test Plan:
- Mapped read, addr 27'h0004123, sdram_ack returned 1 cycle after sdram_req with rdata 8'h5A -> sdram_addr = 27'h0004123, cpu_wait high for 2 cycles, cpu_data_valid pulse with cpu_data = 8'h5A two cycles after the strobe.
- Unmapped read (map_ram_cs = 0) -> sdram_req never asserts, cpu_wait stays 0, cpu_data = 8'hFF with valid pulse the next cycle.
- TIMEOUT_CYCLES = 4, no ack -> sdram_req high for 4 cycles then drops, cpu_data = 8'hFF with valid pulse, timeout_err = 1 and stays 1 through later successful reads until reset.
- Ack arriving in the same cycle as timeout expiry, rdata 8'h33 -> cpu_data = 8'h33, timeout_err stays 0.
- Reset asserted while in WAIT, ack given 2 cycles later -> sdram_req is 0 after reset, no cpu_data_valid, FSM in IDLE, and the next read completes normally.
- With MAPPER_ROM_FETCH_CACHE_EN: read 27'h10 (rdata 8'hC3), then read 27'h10 again -> second read has no sdram_req and no wait, and returns 8'hC3 one cycle after its strobe. A following read of 27'h11 goes to SDRAM.

Source files
------------

// File: rtl/mapper_rom_fetch.sv
// mapper_rom_fetch: turns a mapper ROM hit into a level-handshake SDRAM
// read. It holds the CPU with cpu_wait and returns the byte with a one-cycle
// cpu_data_valid pulse. Unmapped reads and timed-out reads return
// UNMAPPED_DATA. The optional single-entry read cache is enabled by
// defining MAPPER_ROM_FETCH_CACHE_EN.
// Ports: clk, reset (sync, active-high)
//        cpu_req/cpu_rd/map_ram_cs/map_addr -> cpu_wait/cpu_data/cpu_data_valid
//        sdram_req/sdram_addr <-> sdram_ack/sdram_rdata, timeout_err (sticky)
module mapper_rom_fetch #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  UNMAPPED_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rd,
  input  logic        map_ram_cs,
  input  logic [26:0] map_addr,
  output logic        cpu_wait,
  output logic [7:0]  cpu_data,
  output logic        cpu_data_valid,
  output logic        sdram_req,
  output logic [26:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [7:0]  sdram_rdata,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_req;
  logic          hit;
  logic          start;
  logic          busy;
  logic          expire;

  assign rd_req = cpu_req & cpu_rd;
  assign busy   = (state == ISSUE) | (state == WAIT);
  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef MAPPER_ROM_FETCH_CACHE_EN
  logic        cache_valid;
  logic [26:0] cache_tag;
  logic [7:0]  cache_data;

  assign hit = cache_valid & (cache_tag == map_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if (busy) begin
      if (sdram_ack) begin
        cache_valid <= 1'b1;
        cache_tag   <= sdram_addr;
        cache_data  <= sdram_rdata;
      end else if (expire) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign start    = rd_req & map_ram_cs & ~hit & (state == IDLE);
  assign cpu_wait = start | busy;

  // sdram_req is raised on the start edge so the first request cycle
  // (ISSUE) can already take an ack; ISSUE and WAIT share the ack and
  // timeout handling, ISSUE being the cycle with counter == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      sdram_req      <= 1'b0;
      sdram_addr     <= '0;
      cpu_data       <= 8'hFF;
      cpu_data_valid <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      cpu_data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sdram_addr <= map_addr;
            sdram_req  <= 1'b1;
            cnt        <= '0;
            state      <= ISSUE;
          end else if (rd_req & ~map_ram_cs) begin
            cpu_data       <= UNMAPPED_DATA;
            cpu_data_valid <= 1'b1;
          end
`ifdef MAPPER_ROM_FETCH_CACHE_EN
          else if (rd_req & hit) begin
            cpu_data       <= cache_data;
            cpu_data_valid <= 1'b1;
          end
`endif
        end
        ISSUE, WAIT: begin
          if (sdram_ack) begin
            cpu_data       <= sdram_rdata;
            cpu_data_valid <= 1'b1;
            sdram_req      <= 1'b0;
            state          <= DONE;
          end else if (expire) begin
            cpu_data       <= UNMAPPED_DATA;
            cpu_data_valid <= 1'b1;
            sdram_req      <= 1'b0;
            timeout_err    <= 1'b1;
            state          <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_rom_fetch.sv
// tb_mapper_rom_fetch: self-checking bench for mapper_rom_fetch.
// Expected read bytes go through a queue; latency and handshake inline.
module tb_mapper_rom_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rd;
  logic        map_ram_cs;
  logic [26:0] map_addr;
  logic        cpu_wait;
  logic [7:0]  cpu_data;
  logic        cpu_data_valid;
  logic        sdram_req;
  logic [26:0] sdram_addr;
  logic        sdram_ack;
  logic [7:0]  sdram_rdata;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  mapper_rom_fetch #(
    .TIMEOUT_CYCLES(4),
    .UNMAPPED_DATA (8'hFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_rd        (cpu_rd),
    .map_ram_cs    (map_ram_cs),
    .map_addr      (map_addr),
    .cpu_wait      (cpu_wait),
    .cpu_data      (cpu_data),
    .cpu_data_valid(cpu_data_valid),
    .sdram_req     (sdram_req),
    .sdram_addr    (sdram_addr),
    .sdram_ack     (sdram_ack),
    .sdram_rdata   (sdram_rdata),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_req     = 1'b0;
    cpu_rd      = 1'b0;
    map_ram_cs  = 1'b0;
    map_addr    = '0;
    sdram_ack   = 1'b0;
    sdram_rdata = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // One CPU read strobe; ack is given in the (ack_lat)th request cycle
  // (ack_lat < 0: never). Returns at posedge+1 of the cycle after valid.
  task automatic do_read(
    input  logic [26:0] a,
    input  logic        cs,
    input  int          ack_lat,
    input  logic [7:0]  rd,
    output int          wait_cyc,
    output int          req_cyc,
    output int          valid_at,
    output logic [7:0]  data,
    output logic        addr_ok
  );
    wait_cyc = 0;
    req_cyc  = 0;
    valid_at = -1;
    data     = 8'h00;
    addr_ok  = 1'b1;
    cpu_req    = 1'b1;
    cpu_rd     = 1'b1;
    map_ram_cs = cs;
    map_addr   = a;
    for (int c = 0; c < 40; c++) begin
      sdram_ack   = (ack_lat >= 0) && (sdram_req === 1'b1)
                    && (req_cyc == ack_lat);
      sdram_rdata = rd;
      @(negedge clk);
      if (cpu_wait === 1'b1) wait_cyc++;
      if (sdram_req === 1'b1) begin
        req_cyc++;
        if (sdram_addr !== a) addr_ok = 1'b0;
      end
      if (cpu_data_valid === 1'b1) begin
        valid_at = c;
        data     = cpu_data;
        break;
      end
      cyc();
      cpu_req = 1'b0;
    end
    cyc();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    apply_reset();
    @(negedge clk);
    n_cmp += 6;
    if (sdram_req !== 1'b0) begin
      n_bad++; $display("FAIL reset_req got %b want 0", sdram_req);
    end
    if (sdram_addr !== 27'h0) begin
      n_bad++; $display("FAIL reset_addr got %h want 0", sdram_addr);
    end
    if (cpu_data !== 8'hFF) begin
      n_bad++; $display("FAIL reset_data got %h want ff", cpu_data);
    end
    if (cpu_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0", cpu_data_valid);
    end
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_terr got %b want 0", timeout_err);
    end
    if (cpu_wait !== 1'b0) begin
      n_bad++; $display("FAIL reset_wait got %b want 0", cpu_wait);
    end
    cyc();
  endtask

  task automatic test_mapped(
    input string nm, input logic [26:0] a, input logic [7:0] d
  );
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    exp_q.push_back(d);
    do_read(a, 1'b1, 0, d, w, r, v, got, ok);
    want = exp_q.pop_front();
    @(negedge clk);
    n_cmp += 6;
    if (got !== want) begin
      n_bad++; $display("FAIL %s_data got %h want %h", nm, got, want);
    end
    if (w != 2) begin
      n_bad++; $display("FAIL %s_wait got %0d want 2", nm, w);
    end
    if (r != 1) begin
      n_bad++; $display("FAIL %s_req got %0d want 1", nm, r);
    end
    if (v != 2) begin
      n_bad++; $display("FAIL %s_lat got %0d want 2", nm, v);
    end
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL %s_addr got bad want %h", nm, a);
    end
    if (cpu_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_pulse got %b want 0", nm, cpu_data_valid);
    end
    cyc();
  endtask

  task automatic test_unmapped();
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    exp_q.push_back(8'hFF);
    do_read(27'h0000777, 1'b0, 0, 8'h12, w, r, v, got, ok);
    want = exp_q.pop_front();
    n_cmp += 4;
    if (got !== want) begin
      n_bad++; $display("FAIL unmap_data got %h want %h", got, want);
    end
    if (w != 0) begin
      n_bad++; $display("FAIL unmap_wait got %0d want 0", w);
    end
    if (r != 0) begin
      n_bad++; $display("FAIL unmap_req got %0d want 0", r);
    end
    if (v != 1) begin
      n_bad++; $display("FAIL unmap_lat got %0d want 1", v);
    end
  endtask

  task automatic test_ack_at_timeout();
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    exp_q.push_back(8'h33);
    do_read(27'h0000500, 1'b1, 3, 8'h33, w, r, v, got, ok);
    want = exp_q.pop_front();
    n_cmp += 4;
    if (got !== want) begin
      n_bad++; $display("FAIL coinc_data got %h want %h", got, want);
    end
    if (v != 5) begin
      n_bad++; $display("FAIL coinc_lat got %0d want 5", v);
    end
    if (r != 4) begin
      n_bad++; $display("FAIL coinc_req got %0d want 4", r);
    end
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL coinc_terr got %b want 0", timeout_err);
    end
  endtask

  task automatic test_timeout();
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    exp_q.push_back(8'hFF);
    do_read(27'h0000600, 1'b1, -1, 8'h99, w, r, v, got, ok);
    want = exp_q.pop_front();
    n_cmp += 5;
    if (got !== want) begin
      n_bad++; $display("FAIL tmo_data got %h want %h", got, want);
    end
    if (r != 4) begin
      n_bad++; $display("FAIL tmo_req got %0d want 4", r);
    end
    if (w != 5) begin
      n_bad++; $display("FAIL tmo_wait got %0d want 5", w);
    end
    if (v != 5) begin
      n_bad++; $display("FAIL tmo_lat got %0d want 5", v);
    end
    if (timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_terr got %b want 1", timeout_err);
    end
    test_mapped("sticky", 27'h0000601, 8'hA7);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL sticky_terr got %b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    int req_hi = 0;
    cpu_req    = 1'b1;
    cpu_rd     = 1'b1;
    map_ram_cs = 1'b1;
    map_addr   = 27'h0000900;
    cyc();
    cpu_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sdram_ack   = (c == 2);
      sdram_rdata = 8'h99;
      @(negedge clk);
      if (cpu_data_valid === 1'b1) pulses++;
      if (sdram_req !== 1'b0) req_hi++;
      if (c == 0) begin
        n_cmp++;
        if (cpu_wait !== 1'b0) begin
          n_bad++; $display("FAIL rstmid_wait got %b want 0", cpu_wait);
        end
      end
      cyc();
    end
    idle_in();
    n_cmp += 3;
    if (pulses != 0) begin
      n_bad++; $display("FAIL rstmid_valid got %0d want 0", pulses);
    end
    if (req_hi != 0) begin
      n_bad++; $display("FAIL rstmid_req got %0d want 0", req_hi);
    end
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_terr got %b want 0", timeout_err);
    end
    test_mapped("after_rst", 27'h0000901, 8'h6C);
  endtask

  task automatic test_back_to_back();
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      do_read(27'h0001000 + 27'(i), 1'b1, i, 8'h80 + 8'(i),
              w, r, v, got, ok);
      want = exp_q.pop_front();
      n_cmp += 3;
      if (got !== want) begin
        n_bad++; $display("FAIL b2b%0d_data got %h want %h", i, got, want);
      end
      if (v != 2 + i) begin
        n_bad++; $display("FAIL b2b%0d_lat got %0d want %0d", i, v, 2 + i);
      end
      if (ok !== 1'b1 || r != i + 1) begin
        n_bad++;
        $display("FAIL b2b%0d_req got %0d want %0d", i, r, i + 1);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [7:0] want;
    exp_q.push_back(8'h44);
    cpu_req    = 1'b1;
    cpu_rd     = 1'b1;
    map_ram_cs = 1'b1;
    map_addr   = 27'h0000222;
    cyc();
    map_addr    = 27'h0000333;
    sdram_ack   = 1'b1;
    sdram_rdata = 8'h44;
    @(negedge clk);
    n_cmp++;
    if (sdram_addr !== 27'h0000222) begin
      n_bad++; $display("FAIL busy_addr got %h want 222", sdram_addr);
    end
    cyc();
    sdram_ack = 1'b0;
    @(negedge clk);
    want = exp_q.pop_front();
    n_cmp += 3;
    if (cpu_data_valid !== 1'b1) begin
      n_bad++; $display("FAIL busy_valid got %b want 1", cpu_data_valid);
    end
    if (cpu_data !== want) begin
      n_bad++; $display("FAIL busy_data got %h want %h", cpu_data, want);
    end
    if (cpu_wait !== 1'b0) begin
      n_bad++; $display("FAIL busy_done_wait got %b want 0", cpu_wait);
    end
    cyc();
    idle_in();
    @(negedge clk);
    n_cmp += 2;
    if (sdram_req !== 1'b0) begin
      n_bad++; $display("FAIL busy_queued got %b want 0", sdram_req);
    end
    if (cpu_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL busy_pulse got %b want 0", cpu_data_valid);
    end
    cyc();
  endtask

  task automatic test_write_and_stray_ack();
    cpu_req     = 1'b1;
    cpu_rd      = 1'b0;
    map_ram_cs  = 1'b1;
    map_addr    = 27'h0000444;
    sdram_ack   = 1'b1;
    sdram_rdata = 8'h77;
    @(negedge clk);
    n_cmp++;
    if (cpu_wait !== 1'b0) begin
      n_bad++; $display("FAIL wr_wait got %b want 0", cpu_wait);
    end
    cyc();
    idle_in();
    @(negedge clk);
    n_cmp += 3;
    if (sdram_req !== 1'b0) begin
      n_bad++; $display("FAIL wr_req got %b want 0", sdram_req);
    end
    if (cpu_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL wr_valid got %b want 0", cpu_data_valid);
    end
    if (cpu_data === 8'h77) begin
      n_bad++; $display("FAIL stray_ack_data got %h want not 77", cpu_data);
    end
    cyc();
  endtask

`ifdef MAPPER_ROM_FETCH_CACHE_EN
  task automatic test_cache();
    int w, r, v;
    logic [7:0] got;
    logic [7:0] want;
    logic ok;
    test_mapped("fill", 27'h0000010, 8'hC3);
    exp_q.push_back(8'hC3);
    do_read(27'h0000010, 1'b1, 0, 8'h00, w, r, v, got, ok);
    want = exp_q.pop_front();
    n_cmp += 4;
    if (got !== want) begin
      n_bad++; $display("FAIL hit_data got %h want %h", got, want);
    end
    if (w != 0) begin
      n_bad++; $display("FAIL hit_wait got %0d want 0", w);
    end
    if (r != 0) begin
      n_bad++; $display("FAIL hit_req got %0d want 0", r);
    end
    if (v != 1) begin
      n_bad++; $display("FAIL hit_lat got %0d want 1", v);
    end
    test_mapped("miss", 27'h0000011, 8'h3C);
  endtask
`endif

  initial begin
    reset = 1'b0;
    idle_in();
    test_reset();
    test_mapped("mapped", 27'h0004123, 8'h5A);
    test_unmapped();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_busy_ignored();
    test_write_and_stray_ack();
`ifdef MAPPER_ROM_FETCH_CACHE_EN
    apply_reset();
    test_cache();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
